multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32I datapath: register file, sign extender, shared ALU and unified instruction/data memory.
//  Replaces the single-cycle combinational control unit; one instruction takes 3-5 states, plus memory wait states.
//  Drives all datapath selects, enables and ALU operation codes, and raises trap on unsupported encodings.
// PARAMETERS
//  none; encodings below are fixed and shared
// PORTS
//  clk          in   1  system clock, all state updates on rising edge
//  rst          in   1  reset, asynchronous, active-low
//  op           in   7  instr[6:0] from instruction register
//  funct3       in   3  instr[14:12]
//  funct7b5     in   1  instr[30]
//  zero         in   1  ALU result == 0
//  negative     in   1  ALU result[31] (rs1-rs2 sign, signed compare)
//  mem_ready    in   1  memory access completes this cycle
//  PCWrite      out  1  load PC from Result
//  AdrSrc       out  1  0: memory address = PC; 1: address = Result
//  IRWrite      out  1  latch instruction register and OldPC
//  MemWrite     out  1  store strobe
//  RegWrite     out  1  register-file write enable
//  ResultSrc    out  2  00 ALUOut, 01 Data, 10 ALUResult
//  ALUSrcA      out  2  00 PC, 01 OldPC, 10 rd1
//  ALUSrcB      out  2  00 rd2, 01 ImmExt, 10 constant 4
//  ALUControl   out  4  ALU operation, see encoding
//  ImmSrc       out  3  000 I, 001 S, 010 B, 011 U, 100 J
//  retire       out  1  one-cycle pulse in the final state of each instruction
//  trap         out  1  sticky; high in TRAP state
// BEHAVIOUR
//  Reset: state=FETCH; all enables 0; selects 0; ALUControl=ADD; trap=0; retire=0.
//  Outputs are a combinational (Moore) decode of state, except:
//   PCWrite in BRANCH and ImmSrc/ALUControl, which also depend on op/funct.
//  ALUControl: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101,
//   SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASSB 1010.
//  FETCH: AdrSrc=0, A=00, B=10, ADD, ResultSrc=10.
//   IRWrite=PCWrite=mem_ready. Stays in FETCH while !mem_ready; otherwise goes to DECODE.
//  DECODE: A=01, B=01, ADD (ALUOut = branch/jal target). ImmSrc from op. Dispatch:
//   0000011 -> MEMADR; 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI;
//   0110111 -> EXECI (PASSB); 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR;
//   any other op -> TRAP.
//  MEMADR: A=10, B=01, ADD. Goes to MEMRD for loads, MEMWR for stores.
//  MEMRD: AdrSrc=1, ResultSrc=00. Stays while !mem_ready; otherwise goes to MEMWB.
//  MEMWB: ResultSrc=01, RegWrite=1, retire=1. Goes to FETCH.
//  MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=1 until mem_ready. When mem_ready: retire=1, go to FETCH.
//  EXECR/EXECI: A=10, B=00 (R) or B=01 (I). ALUControl from funct3 and funct7b5:
//   000 ADD, or SUB only for R-type with b5=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR;
//   101 SRL/SRA by b5; 110 OR; 111 AND. Then ALUWB.
//  ALUWB: ResultSrc=00, RegWrite=1, retire=1. Goes to FETCH.
//  BRANCH: A=10, B=00, SUB, ResultSrc=00. PCWrite = taken; retire=1.
//   beq: zero; bne: !zero; blt: negative; bge: !negative.
//   funct3 010, 011, 110, 111 -> TRAP; PC is not written.
//  JAL: A=01, B=10, ADD, ResultSrc=00, PCWrite=1 (target). Then ALUWB (link = OldPC+4).
//  JALR: A=10, B=01, ADD, ResultSrc=10, PCWrite=1. Then JALRWB.
//   JALRWB: A=01, B=10, ADD, ResultSrc=10, RegWrite=1, retire=1. Goes to FETCH.
//   rs1 is consumed before rd is written, so rd==rs1 is safe.
//  TRAP: all enables 0, trap=1; held until reset.
//  Reset mid-access: async return to FETCH. No write strobe may glitch high during the reset edge.
//  Cycles per instruction with no memory waits: branch 3, R/I/sw 4, jal 4, jalr 4, lw 5.
//   Each !mem_ready cycle adds 1.
// STRUCTURE
//  Package riscv_pkg: state_t enum, alu_ctrl_t constants, opcode_t constants, ImmSrc codes, select encodings.
//  Sub-module alu_decoder (funct3/funct7b5/op -> ALUControl): combinational, reused by EXECR/EXECI.
//  Main module: state register plus next-state and output always_comb blocks.
// TESTING
//  add x3,x1,x2 with mem_ready=1: FETCH, DECODE, EXECR, ALUWB; RegWrite only in ALUWB; ALUControl=0000; retire on cycle 4.
//  lw with mem_ready low 2 cycles in FETCH and 1 in MEMRD: 8 cycles total; IRWrite pulses once; RegWrite once, ResultSrc=01.
//  beq, zero=1: PCWrite=1 in BRANCH. bne, zero=1: PCWrite=0. blt, negative=1: PCWrite=1. bltu: trap=1 and no PCWrite.
//  jalr x1,0(x1): JALR has PCWrite=1 and ResultSrc=10; JALRWB has RegWrite=1 with A=01, B=10.
//  op=0000000: TRAP after DECODE; trap stays 1 for 20 cycles; rst low returns to FETCH with trap=0.
//  sw with rst asserted while in MEMWR and mem_ready=0: MemWrite drops asynchronously to 0; state=FETCH after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared encodings for the multi-cycle RV32I control path: sequencer state
// codes, ALU operation codes, opcodes, immediate-format codes and the datapath
// select encodings. Also provides imm_src_of(), the opcode -> immediate format
// map used by the sequencer.
// -----------------------------------------------------------------------------
package riscv_pkg;

    // Sequencer states (plain constants so older tools and checkers can bind
    // to the numeric codes directly).
    typedef logic [3:0] state_t;
    localparam state_t S_FETCH  = 4'd0;
    localparam state_t S_DECODE = 4'd1;
    localparam state_t S_MEMADR = 4'd2;
    localparam state_t S_MEMRD  = 4'd3;
    localparam state_t S_MEMWB  = 4'd4;
    localparam state_t S_MEMWR  = 4'd5;
    localparam state_t S_EXECR  = 4'd6;
    localparam state_t S_EXECI  = 4'd7;
    localparam state_t S_ALUWB  = 4'd8;
    localparam state_t S_BRANCH = 4'd9;
    localparam state_t S_JAL    = 4'd10;
    localparam state_t S_JALR   = 4'd11;
    localparam state_t S_JALRWB = 4'd12;
    localparam state_t S_TRAP   = 4'd13;

    // ALU operation codes
    typedef logic [3:0] alu_ctrl_t;
    localparam alu_ctrl_t ALU_ADD   = 4'b0000;
    localparam alu_ctrl_t ALU_SUB   = 4'b0001;
    localparam alu_ctrl_t ALU_AND   = 4'b0010;
    localparam alu_ctrl_t ALU_OR    = 4'b0011;
    localparam alu_ctrl_t ALU_XOR   = 4'b0100;
    localparam alu_ctrl_t ALU_SLL   = 4'b0101;
    localparam alu_ctrl_t ALU_SRL   = 4'b0110;
    localparam alu_ctrl_t ALU_SRA   = 4'b0111;
    localparam alu_ctrl_t ALU_SLT   = 4'b1000;
    localparam alu_ctrl_t ALU_SLTU  = 4'b1001;
    localparam alu_ctrl_t ALU_PASSB = 4'b1010;

    // Supported opcodes
    typedef logic [6:0] opcode_t;
    localparam opcode_t OP_LOAD   = 7'b0000011;
    localparam opcode_t OP_STORE  = 7'b0100011;
    localparam opcode_t OP_R      = 7'b0110011;
    localparam opcode_t OP_I      = 7'b0010011;
    localparam opcode_t OP_LUI    = 7'b0110111;
    localparam opcode_t OP_BRANCH = 7'b1100011;
    localparam opcode_t OP_JAL    = 7'b1101111;
    localparam opcode_t OP_JALR   = 7'b1100111;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Result mux
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A mux
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALU operand B mux
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Branch funct3 values the datapath can evaluate from zero/negative
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    function automatic logic [2:0] imm_src_of(input opcode_t op);
        logic [2:0] imm;
        case (op)
            OP_STORE:  imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_LUI:    imm = IMM_U;
            OP_JAL:    imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational ALU operation decode for the execute states.
// Ports:
//   op_i        opcode (only R-type vs others and LUI matter)
//   funct3_i    instr[14:12]
//   funct7b5_i  instr[30]
//   alu_ctrl_o  ALU operation code
// -----------------------------------------------------------------------------
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        if (op_i == OP_LUI) begin
            alu_ctrl_o = ALU_PASSB;
        end else begin
            case (funct3_i)
                // bit30 on an I-type is part of the immediate, so only
                // R-type may select SUB.
                3'b000:  alu_ctrl_o = (op_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_ctrl_o = ALU_SLL;
                3'b010:  alu_ctrl_o = ALU_SLT;
                3'b011:  alu_ctrl_o = ALU_SLTU;
                3'b100:  alu_ctrl_o = ALU_XOR;
                3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                3'b110:  alu_ctrl_o = ALU_OR;
                default: alu_ctrl_o = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle sequencer for the RV32I datapath (register file, sign extender,
// shared ALU, unified instruction/data memory). Each instruction walks
// 3-5 states plus memory wait states; unsupported encodings park in TRAP.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   op/funct3/funct7b5 instruction fields from the instruction register
//   zero, negative    ALU flags used by branches
//   mem_ready         memory completion handshake
//   PCWrite..ImmSrc   datapath enables, selects and ALU operation
//   retire            one-cycle pulse in each instruction's final state
//   trap              high while in TRAP (held until reset)
//   state_dbg_o       current sequencer state
//
// Memory handshake: the sequencer presents an access (address select and,
// for stores, MemWrite) for as long as it sits in FETCH, MEMRD or MEMWR.
// The access completes in the cycle mem_ready is high; that cycle's strobes
// stay asserted and the state advances on the following rising edge.
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       negative,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       retire,
    output logic       trap,
    output logic [3:0] state_dbg_o
);

    state_t    state_q, state_d;
    alu_ctrl_t exec_alu;
    logic      branch_ok;
    logic      branch_taken;

    alu_decoder u_alu_decoder (
        .op_i       (op),
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .alu_ctrl_o (exec_alu)
    );

    // Only conditions expressible from zero/negative are supported; the
    // unsigned compares (and the reserved encodings) trap.
    always_comb begin
        branch_ok    = 1'b1;
        branch_taken = 1'b0;
        case (funct3)
            F3_BEQ:  branch_taken = zero;
            F3_BNE:  branch_taken = !zero;
            F3_BLT:  branch_taken = negative;
            F3_BGE:  branch_taken = !negative;
            default: branch_ok    = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I, OP_LUI:      state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (op == OP_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = branch_ok ? S_FETCH : S_TRAP;
            S_JAL:    state_d = S_ALUWB;
            S_JALR:   state_d = S_JALRWB;
            S_JALRWB: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore decode of state. While rst is low every output is forced to its
    // idle value so no strobe can be seen high around the reset edge, even
    // in the same delta as the asynchronous state change.
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ALUControl = ALU_ADD;
        ImmSrc     = IMM_I;
        retire     = 1'b0;
        trap       = 1'b0;
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                S_DECODE: begin
                    // ALUOut captures OldPC+imm: the branch/jal target.
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = imm_src_of(op);
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_RD1;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = imm_src_of(op);
                end
                S_MEMRD: begin
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegWrite  = 1'b1;
                    retire    = 1'b1;
                end
                S_MEMWR: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                    retire   = mem_ready;
                end
                S_EXECR: begin
                    ALUSrcA    = SRCA_RD1;
                    ALUSrcB    = SRCB_RD2;
                    ALUControl = exec_alu;
                end
                S_EXECI: begin
                    ALUSrcA    = SRCA_RD1;
                    ALUSrcB    = SRCB_IMM;
                    ALUControl = exec_alu;
                    ImmSrc     = imm_src_of(op);
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA    = SRCA_RD1;
                    ALUSrcB    = SRCB_RD2;
                    ALUControl = ALU_SUB;
                    PCWrite    = branch_ok && branch_taken;
                    retire     = branch_ok;
                end
                S_JAL: begin
                    // PC <- target held in ALUOut; ALU forms the link OldPC+4.
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_FOUR;
                    PCWrite = 1'b1;
                end
                S_JALR: begin
                    // PC is loaded from rs1+imm before rd is written, which
                    // keeps rd == rs1 safe.
                    ALUSrcA   = SRCA_RD1;
                    ALUSrcB   = SRCB_IMM;
                    ResultSrc = RES_ALURESULT;
                    PCWrite   = 1'b1;
                end
                S_JALRWB: begin
                    ALUSrcA   = SRCA_OLDPC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                    RegWrite  = 1'b1;
                    retire    = 1'b1;
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign state_dbg_o = state_q;

endmodule
